// File: rtl/loop_stack.sv
`default_nettype none
// ============================================================================
//  Module      : loop_stack
//  Description : Loop-control unit. Keeps a LIFO of loop-start addresses,
//                issues zero-latency PC loads on loop-close, and runs a
//                nesting-aware forward-skip mode for loops entered with a
//                zero data cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module loop_stack #(
    parameter int WORD_SIZE  = 16,
    parameter int DEPTH      = 16,
    parameter int NEST_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    input  logic                         loop_open,
    input  logic                         loop_close,
    input  logic                         cell_zero,
    input  logic [WORD_SIZE-1:0]         pc,
    output logic [WORD_SIZE-1:0]         jump_target,
    output logic                         jump_set,
    output logic                         skip,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_DW = $clog2(DEPTH+1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [WORD_SIZE-1:0]  r_stack [DEPTH];
    logic [c_DW-1:0]       r_depth;
    logic [c_DW-1:0]       w_depth_next;
    logic [NEST_WIDTH-1:0] r_nest;
    logic [NEST_WIDTH-1:0] w_nest_next;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_push;
    logic                  w_open;
    logic                  w_close;
    logic                  w_empty;
    logic                  w_full;
    logic [c_AW-1:0]       w_top_idx;
    logic [c_AW-1:0]       w_push_idx;
    logic [WORD_SIZE-1:0]  w_top;

    // Open and close together is illegal and collapses to a no-op.
    assign w_open  = instr_valid & loop_open  & ~loop_close;
    assign w_close = instr_valid & loop_close & ~loop_open;

    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == c_DW'(DEPTH));
    // Push index is only used when not full, so the low bits suffice.
    assign w_push_idx = r_depth[c_AW-1:0];
    assign w_top_idx  = c_AW'(r_depth - c_DW'(1));
    assign w_top      = r_stack[w_top_idx];

    assign skip      = (r_state == ST_SKIP);
    assign depth     = r_depth;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Next-state, stack control and the combinational PC-load outputs.
    always_comb begin
        w_state_next = r_state;
        w_depth_next = r_depth;
        w_nest_next  = r_nest;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        w_push       = 1'b0;
        jump_set     = 1'b0;
        jump_target  = '0;
        case (r_state)
            ST_RUN: begin
                if (w_open) begin
                    if (cell_zero) begin
                        w_state_next = ST_SKIP;
                        w_nest_next  = NEST_WIDTH'(1);
                    end else if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_depth_next = r_depth + c_DW'(1);
                    end
                end else if (w_close) begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else if (cell_zero) begin
                        w_depth_next = r_depth - c_DW'(1);
                    end else begin
                        // Jump to the instruction after the loop-open.
                        jump_set    = 1'b1;
                        jump_target = w_top + WORD_SIZE'(1);
                    end
                end
            end
            ST_SKIP: begin
                if (w_open) begin
                    if (r_nest == '1) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_nest_next = r_nest + NEST_WIDTH'(1);
                    end
                end else if (w_close) begin
                    w_nest_next = r_nest - NEST_WIDTH'(1);
                    if (r_nest == NEST_WIDTH'(1)) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Control state with asynchronous reset; error flags are sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_depth     <= '0;
            r_nest      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_depth     <= w_depth_next;
            r_nest      <= w_nest_next;
            r_overflow  <= r_overflow  | w_ovf_set;
            r_underflow <= r_underflow | w_unf_set;
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loop_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loop_stack
//  Description : Directed self-checking bench for loop_stack (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_loop_stack;

    localparam int WS = 16;
    localparam int DP = 4;
    localparam int NW = 8;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          loop_open;
    logic          loop_close;
    logic          cell_zero;
    logic [WS-1:0] pc;
    logic [WS-1:0] jump_target;
    logic          jump_set;
    logic          skip;
    logic [2:0]    depth;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int checks;
    int errors;

    loop_stack #(.WORD_SIZE(WS), .DEPTH(DP), .NEST_WIDTH(NW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .loop_open(loop_open), .loop_close(loop_close), .cell_zero(cell_zero),
        .pc(pc), .jump_target(jump_target), .jump_set(jump_set), .skip(skip),
        .depth(depth), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench never presents open and close together.
    always @(posedge clk) begin
        assert (!(instr_valid && loop_open && loop_close));
    end

    task automatic idle();
        instr_valid = 1'b0;
        loop_open   = 1'b0;
        loop_close  = 1'b0;
        cell_zero   = 1'b0;
        pc          = '0;
    endtask

    // Present an instruction; caller then waits for the edge.
    task automatic present(input logic o, input logic c, input logic z, input logic [WS-1:0] p);
        instr_valid = 1'b1;
        loop_open   = o;
        loop_close  = c;
        cell_zero   = z;
        pc          = p;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic instr(input logic o, input logic c, input logic z, input logic [WS-1:0] p);
        present(o, c, z, p);
        edge_step();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({skip, depth, empty, full, overflow, underflow, jump_set} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got skip=%0b depth=%0d empty=%0b full=%0b ovf=%0b unf=%0b js=%0b expected 0 0 1 0 0 0 0",
                     skip, depth, empty, full, overflow, underflow, jump_set);
        end
    endtask

    task automatic test_nested();
        do_reset();
        instr(1'b1, 1'b0, 1'b0, 16'd3);
        instr(1'b1, 1'b0, 1'b0, 16'd7);
        checks++;
        if (depth !== 3'd2) begin
            errors++; $display("FAIL nested_depth2: got %0d expected 2", depth);
        end
        present(1'b0, 1'b1, 1'b0, 16'd9);
        checks++;
        if (jump_set !== 1'b1 || jump_target !== 16'd8) begin
            errors++; $display("FAIL nested_jump_inner: got js=%0b tgt=%0h expected js=1 tgt=8", jump_set, jump_target);
        end
        edge_step();
        checks++;
        if (depth !== 3'd2) begin
            errors++; $display("FAIL nested_depth_after_jump: got %0d expected 2", depth);
        end
        present(1'b0, 1'b1, 1'b1, 16'd9);
        checks++;
        if (jump_set !== 1'b0 || jump_target !== 16'd0) begin
            errors++; $display("FAIL nested_pop_nojump: got js=%0b tgt=%0h expected js=0 tgt=0", jump_set, jump_target);
        end
        edge_step();
        checks++;
        if (depth !== 3'd1) begin
            errors++; $display("FAIL nested_depth_after_pop: got %0d expected 1", depth);
        end
        present(1'b0, 1'b1, 1'b0, 16'd12);
        checks++;
        if (jump_set !== 1'b1 || jump_target !== 16'd4) begin
            errors++; $display("FAIL nested_jump_outer: got js=%0b tgt=%0h expected js=1 tgt=4", jump_set, jump_target);
        end
        edge_step();
    endtask

    task automatic test_skip();
        do_reset();
        instr(1'b1, 1'b0, 1'b1, 16'd2);
        checks++;
        if (skip !== 1'b1 || depth !== 3'd0) begin
            errors++; $display("FAIL skip_enter: got skip=%0b depth=%0d expected 1 0", skip, depth);
        end
        instr(1'b1, 1'b0, 1'b0, 16'd3);
        present(1'b0, 1'b1, 1'b0, 16'd4);
        checks++;
        if (jump_set !== 1'b0 || skip !== 1'b1) begin
            errors++; $display("FAIL skip_inner_close: got js=%0b skip=%0b expected 0 1", jump_set, skip);
        end
        edge_step();
        present(1'b0, 1'b1, 1'b0, 16'd5);
        checks++;
        if (jump_set !== 1'b0 || skip !== 1'b1) begin
            errors++; $display("FAIL skip_match_close: got js=%0b skip=%0b expected 0 1", jump_set, skip);
        end
        edge_step();
        checks++;
        if (skip !== 1'b0 || depth !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL skip_exit: got skip=%0b depth=%0d ovf=%0b unf=%0b expected 0 0 0 0", skip, depth, overflow, underflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) instr(1'b1, 1'b0, 1'b0, 16'(10 + i));
        checks++;
        if (full !== 1'b1 || depth !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_at_full: got full=%0b depth=%0d ovf=%0b expected 1 4 0", full, depth, overflow);
        end
        instr(1'b1, 1'b0, 1'b0, 16'd14);
        checks++;
        if (full !== 1'b1 || depth !== 3'd4 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_fifth_push: got full=%0b depth=%0d ovf=%0b expected 1 4 1", full, depth, overflow);
        end
        present(1'b0, 1'b1, 1'b0, 16'd20);
        checks++;
        if (jump_set !== 1'b1 || jump_target !== 16'd14) begin
            errors++; $display("FAIL ovf_top_kept: got js=%0b tgt=%0h expected js=1 tgt=e", jump_set, jump_target);
        end
        edge_step();
    endtask

    task automatic test_underflow();
        do_reset();
        present(1'b0, 1'b1, 1'b0, 16'd6);
        checks++;
        if (jump_set !== 1'b0 || jump_target !== 16'd0) begin
            errors++; $display("FAIL unf_nojump: got js=%0b tgt=%0h expected 0 0", jump_set, jump_target);
        end
        edge_step();
        checks++;
        if (underflow !== 1'b1 || depth !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL unf_flag: got unf=%0b depth=%0d empty=%0b expected 1 0 1", underflow, depth, empty);
        end
        // Sticky flag must not block normal pushes.
        instr(1'b1, 1'b0, 1'b0, 16'd1);
        checks++;
        if (underflow !== 1'b1 || depth !== 3'd1) begin
            errors++; $display("FAIL unf_sticky: got unf=%0b depth=%0d expected 1 1", underflow, depth);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr(1'b0, 1'b1, 1'b0, 16'd0);     // sets underflow
        instr(1'b1, 1'b0, 1'b0, 16'd30);    // depth 1
        instr(1'b1, 1'b0, 1'b1, 16'd31);    // enter skip
        instr(1'b1, 1'b0, 1'b0, 16'd32);    // nested open in skip
        checks++;
        if (skip !== 1'b1 || underflow !== 1'b1 || depth !== 3'd1) begin
            errors++; $display("FAIL async_pre: got skip=%0b unf=%0b depth=%0d expected 1 1 1", skip, underflow, depth);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (skip !== 1'b0 || depth !== 3'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL async_reset: got skip=%0b depth=%0d ovf=%0b unf=%0b expected 0 0 0 0", skip, depth, overflow, underflow);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        do_reset();
        instr(1'b1, 1'b0, 1'b0, 16'hFFFF);
        present(1'b0, 1'b1, 1'b0, 16'h0010);
        checks++;
        if (jump_set !== 1'b1 || jump_target !== 16'h0000) begin
            errors++; $display("FAIL wrap_target: got js=%0b tgt=%0h expected js=1 tgt=0", jump_set, jump_target);
        end
        edge_step();
    endtask

    task automatic test_nest_saturate();
        do_reset();
        instr(1'b1, 1'b0, 1'b1, 16'd0);     // nest = 1
        for (int i = 0; i < 254; i++) instr(1'b1, 1'b0, 1'b0, 16'd1);
        checks++;
        if (overflow !== 1'b0 || skip !== 1'b1) begin
            errors++; $display("FAIL nest_at_max: got ovf=%0b skip=%0b expected 0 1", overflow, skip);
        end
        instr(1'b1, 1'b0, 1'b0, 16'd1);     // saturates at 255
        checks++;
        if (overflow !== 1'b1 || skip !== 1'b1) begin
            errors++; $display("FAIL nest_saturate: got ovf=%0b skip=%0b expected 1 1", overflow, skip);
        end
        for (int i = 0; i < 254; i++) instr(1'b0, 1'b1, 1'b0, 16'd2);
        checks++;
        if (skip !== 1'b1) begin
            errors++; $display("FAIL nest_still_skip: got skip=%0b expected 1", skip);
        end
        instr(1'b0, 1'b1, 1'b0, 16'd2);
        checks++;
        if (skip !== 1'b0 || depth !== 3'd0) begin
            errors++; $display("FAIL nest_exit: got skip=%0b depth=%0d expected 0 0", skip, depth);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_nested();
        test_skip();
        test_overflow();
        test_underflow();
        test_async_reset();
        test_wrap();
        test_nest_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
